// File: rtl/motor_sched_pkg.sv
// motor_sched_pkg: command type, scan FSM states and level limit shared by the motor ramp scheduler
package motor_sched_pkg;
  typedef struct packed {
    logic       dir;
    logic [6:0] level;
  } motor_cmd_t;
  typedef enum logic {IDLE, SCAN} state_t;
  localparam int LEVEL_MAX = 127;
endpackage

// File: rtl/motor_ramp_step.sv
// motor_ramp_step: combinational next applied command for one channel given its target, fault and dwell state
module motor_ramp_step
  import motor_sched_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic [7:0] i_cur,
  input  logic [7:0] i_tgt,
  input  logic       i_fault,
  input  logic       i_dwell_done,
  output logic [7:0] o_next,
  output logic       o_set_fault
);
  motor_cmd_t w_cur, w_tgt;
  logic [7:0] w_cl, w_tl, w_step;
  logic [6:0] w_toward, w_dn;
  assign w_cur = i_cur;
  assign w_tgt = i_tgt;
  assign w_cl = {1'b0, w_cur.level};
  assign w_tl = {1'b0, w_tgt.level};
  assign w_step = 8'(STEP);
  // Approach the target by at most one step, landing exactly on it rather than passing it
  assign w_toward = 7'((w_tl >= w_cl) ? ((w_tl - w_cl > w_step) ? w_cl + w_step : w_tl)
                                      : ((w_cl - w_tl > w_step) ? w_cl - w_step : w_tl));
  assign w_dn = 7'((w_cl > w_step) ? w_cl - w_step : 8'd0);
  assign o_set_fault = i_fault;
  assign o_next = i_fault ? {w_cur.dir, 7'd0}
                : (w_cur.dir == w_tgt.dir) ? {w_cur.dir, w_toward}
                : (w_cl != 8'd0) ? {w_cur.dir, w_dn}
                : {i_dwell_done ? w_tgt.dir : w_cur.dir, 7'd0};
endmodule

// File: rtl/motor_ramp_sched.sv
// motor_ramp_sched: per-tick scan that slews each motor's applied command toward its host target and strobes it out
// Optional MOTOR_SCHED_BRAKE_EN adds a per-channel zero-level dwell before a direction reversal.
module motor_ramp_sched
  import motor_sched_pkg::*;
#(
  parameter int NUM_MOTORS  = 5,
  parameter int CH_W        = 3,
  parameter int RAMP_DIV    = 4096,
  parameter int STEP        = 4,
  parameter int BRAKE_TICKS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CH_W-1:0]         cmd_chan,
  input  logic [7:0]              cmd_data,
  input  logic [NUM_MOTORS-1:0]   motor_fault,
  output logic [NUM_MOTORS-1:0]   motor_write,
  output logic [8*NUM_MOTORS-1:0] motor_data,
  output logic [NUM_MOTORS-1:0]   fault_latched,
  output logic                    busy
);
  localparam int CNT_W = $clog2(RAMP_DIV);
  state_t r_state, w_state_nx;
  logic [CH_W-1:0] r_idx, w_idx_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0] r_tgt [NUM_MOTORS];
  logic [7:0] r_data [NUM_MOTORS];
  logic [NUM_MOTORS-1:0] r_wr, r_fl;
  logic w_tick, w_last, w_acc, w_fault, w_set_fault, w_dwell_done;
  logic [7:0] w_cur, w_tgt, w_next;
  assign w_tick = r_cnt == CNT_W'(RAMP_DIV - 1);
  assign w_last = r_idx == CH_W'(NUM_MOTORS - 1);
  assign busy = r_state == SCAN;
  assign cmd_ready = !(busy && r_idx == cmd_chan);
  assign w_acc = cmd_valid && cmd_ready;
  assign motor_write = r_wr;
  assign fault_latched = r_fl;
  for (genvar k = 0; k < NUM_MOTORS; k++) begin : g_out
    assign motor_data[8*k +: 8] = r_data[k];
  end
  always_comb begin
    w_state_nx = (r_state == IDLE) ? (w_tick ? SCAN : IDLE) : (w_last ? IDLE : SCAN);
    w_idx_nx = (r_state == SCAN && !w_last) ? r_idx + CH_W'(1) : '0;
  end
  always_comb begin
    w_cur = '0;
    w_tgt = '0;
    w_fault = 1'b0;
    for (int k = 0; k < NUM_MOTORS; k++) begin
      if (r_idx == CH_W'(k)) begin
        w_cur = r_data[k];
        w_tgt = r_tgt[k];
        w_fault = motor_fault[k] | r_fl[k];
      end
    end
  end
  motor_ramp_step #(.STEP(STEP)) u_step (
    .i_cur        (w_cur),
    .i_tgt        (w_tgt),
    .i_fault      (w_fault),
    .i_dwell_done (w_dwell_done),
    .o_next       (w_next),
    .o_set_fault  (w_set_fault)
  );
`ifdef MOTOR_SCHED_BRAKE_EN
  localparam int DW_W = $clog2(BRAKE_TICKS + 2);
  logic [DW_W-1:0] r_dwell [NUM_MOTORS];
  logic [DW_W-1:0] w_dwell;
  logic w_hold;
  always_comb begin
    w_dwell = '0;
    for (int k = 0; k < NUM_MOTORS; k++) begin
      if (r_idx == CH_W'(k)) w_dwell = r_dwell[k];
    end
  end
  assign w_dwell_done = w_dwell >= DW_W'(BRAKE_TICKS);
  // A tick spent parked at zero while a reversal is pending advances the dwell
  assign w_hold = !w_fault && w_cur[7] != w_tgt[7] && w_cur[6:0] == 7'd0 && !w_dwell_done;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_MOTORS; k++) r_dwell[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_MOTORS; k++) begin
        if (busy && r_idx == CH_W'(k)) r_dwell[k] <= w_hold ? w_dwell + DW_W'(1) : '0;
        else if (w_acc && cmd_chan == CH_W'(k)) r_dwell[k] <= '0;
      end
    end
  end
`else
  assign w_dwell_done = (BRAKE_TICKS >= 0);
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_cnt <= '0;
      r_wr <= '0;
      r_fl <= '0;
      for (int k = 0; k < NUM_MOTORS; k++) begin
        r_tgt[k] <= '0;
        r_data[k] <= '0;
      end
    end else begin
      r_state <= w_state_nx;
      r_idx <= w_idx_nx;
      r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
      r_wr <= '0;
      for (int k = 0; k < NUM_MOTORS; k++) begin
        if (w_acc && cmd_chan == CH_W'(k)) begin
          r_tgt[k] <= cmd_data;
          if (!motor_fault[k]) r_fl[k] <= 1'b0;
        end
        if (busy && r_idx == CH_W'(k)) begin
          r_data[k] <= w_next;
          r_wr[k] <= 1'b1;
          if (w_set_fault) r_fl[k] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_motor_ramp_sched.sv
// tb_motor_ramp_sched: directed self-checking bench for motor_ramp_sched (4 motors, STEP 8, RAMP_DIV 16)
module tb_motor_ramp_sched;
  localparam int RD = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic [2:0] cmd_chan = '0;
  logic [7:0] cmd_data = '0;
  logic [3:0] motor_fault = '0;
  logic cmd_ready, busy;
  logic [3:0] motor_write, fault_latched;
  logic [31:0] motor_data;
  int checks = 0;
  int failures = 0;
  int cyc, nstr;
  logic [3:0] mask;
  logic [7:0] d;
`ifdef MOTOR_SCHED_BRAKE_EN
  localparam int REV_N = 6;
  logic [7:0] rev_exp [REV_N] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h80, 8'h88};
`else
  localparam int REV_N = 4;
  logic [7:0] rev_exp [REV_N] = '{8'h08, 8'h00, 8'h80, 8'h88};
`endif

  always #5 clk = ~clk;

  motor_ramp_sched #(
    .NUM_MOTORS(4), .CH_W(3), .RAMP_DIV(RD), .STEP(8), .BRAKE_TICKS(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_chan      (cmd_chan),
    .cmd_data      (cmd_data),
    .motor_fault   (motor_fault),
    .motor_write   (motor_write),
    .motor_data    (motor_data),
    .fault_latched (fault_latched),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] ch, input logic [7:0] data);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_chan = ch;
    cmd_data = data;
    #1;
    while (!cmd_ready && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("cmd_accept", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_wr(input int ch, output logic [7:0] data, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!motor_write[ch] && n < 64);
    chk("strobe_seen", motor_write[ch], 1'b1);
    data = motor_data[8*ch +: 8];
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_write", motor_write, 4'h0);
    chk("rst_data", motor_data, 32'h0);
    chk("rst_latched", fault_latched, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);
    reset = 1'b0;

    send(3'd1, 8'h40);
    for (int i = 0; i < 8; i++) begin
      wait_wr(1, d, cyc);
      chk("ramp_up_ch1", d, 8'(8 * (i + 1)));
      if (i == 0) begin
        chk("busy_in_scan", busy, 1'b1);
        @(negedge clk);
        chk("strobe_one_cycle", motor_write[1], 1'b0);
      end
    end
    nstr = 0;
    mask = '0;
    for (int i = 0; i < RD; i++) begin
      @(negedge clk);
      nstr += $countones(motor_write);
      mask |= motor_write;
      if (motor_write[1]) chk("ch1_holds", motor_data[15:8], 8'h40);
    end
    chk("strobes_per_tick", nstr, 4);
    chk("strobe_mask", mask, 4'hF);

    send(3'd0, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      wait_wr(0, d, cyc);
      chk("ramp_ch0", d, (8 * (i + 1) > 60) ? 60 : 8 * (i + 1));
    end
    send(3'd0, 8'h3E);
    wait_wr(0, d, cyc);
    chk("no_overshoot", d, 8'h3E);

    send(3'd2, 8'h10);
    wait_wr(2, d, cyc);
    chk("ch2_pre_a", d, 8'h08);
    wait_wr(2, d, cyc);
    chk("ch2_pre_b", d, 8'h10);
    send(3'd2, 8'h88);
    for (int i = 0; i < REV_N; i++) begin
      wait_wr(2, d, cyc);
      chk("reversal", d, rev_exp[i]);
    end

    send(3'd3, 8'h40);
    for (int i = 0; i < 3; i++) begin
      wait_wr(3, d, cyc);
      chk("ramp_ch3", d, 8'(8 * (i + 1)));
    end
    motor_fault = 4'b1000;
    wait_wr(3, d, cyc);
    chk("fault_zero", d, 8'h00);
    chk("fault_latch_set", fault_latched[3], 1'b1);
    send(3'd3, 8'h20);
    chk("fault_beats_cmd", fault_latched[3], 1'b1);
    motor_fault = 4'b0000;
    wait_wr(3, d, cyc);
    chk("fault_sticky", d, 8'h00);
    send(3'd3, 8'h20);
    chk("latch_cleared", fault_latched[3], 1'b0);
    wait_wr(3, d, cyc);
    chk("ramp_restart", d, 8'h08);

    wait_wr(1, d, cyc);
    cmd_valid = 1'b1;
    cmd_chan = 3'd2;
    cmd_data = 8'h90;
    #1;
    chk("ready_low_same_chan", cmd_ready, 1'b0);
    @(negedge clk);
    chk("ch2_strobe", motor_write[2], 1'b1);
    chk("ch2_old_target", motor_data[23:16], 8'h88);
    #1;
    chk("ready_high_next", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_wr(2, d, cyc);
    chk("late_cmd_applied", d, 8'h90);
    send(3'd7, 8'hFF);
    wait_wr(3, d, cyc);
    wait_wr(3, d, cyc);
    chk("ch3_settled", d, 8'h20);
    chk("chan7_no_effect", motor_data, 32'h2090403E);
    chk("chan7_latched", fault_latched, 4'h0);

    wait_wr(0, d, cyc);
    reset = 1'b1;
    @(negedge clk);
    chk("midscan_rst_write", motor_write, 4'h0);
    chk("midscan_rst_data", motor_data, 32'h0);
    chk("midscan_rst_busy", busy, 1'b0);
    chk("midscan_rst_ready", cmd_ready, 1'b1);
    reset = 1'b0;
    wait_wr(0, d, cyc);
    chk("first_strobe_delay", cyc, RD + 1);
    chk("first_strobe_data", d, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
